// File: rtl/onewire_master.sv
// onewire_master: 1-Wire bus master for bus reset/presence and byte write/read slots, timed by a 1 us tick.
// Define ONEWIRE_CRC_EN to add the Dallas/Maxim CRC-8 output crc accumulated over read bits.
module onewire_master #(
   parameter int CLK_MHZ = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] wr_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       presence,
   output logic       busy,
`ifdef ONEWIRE_CRC_EN
   output logic [7:0] crc,
`endif
   output logic       dq_oe,
   input  logic       dq_in
);
   typedef enum logic [2:0] {IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_REL, DONE} state_t;
   localparam int CW = $clog2(CLK_MHZ);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_MHZ - 1);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic tick_q, tick_d, dq_oe_q, dq_oe_d, rsp_valid_q, presence_q, presence_d;
   logic [8:0] us_q, us_d, low_end;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d, rsp_data_q, rsp_data_d;
   logic [1:0] op_q, op_d, sync_q;
   logic accept, dq_s, rd_smp, slot_end;
   assign cmd_ready = state_q == IDLE && !rsp_valid_q;
   assign busy = !cmd_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data = rsp_data_q;
   assign presence = presence_q;
   assign dq_oe = dq_oe_q;
   // us_q counts whole microseconds across a slot's low and release phases
   always_comb begin
      accept = cmd_valid && cmd_ready;
      dq_s = sync_q[1];
      low_end = (op_q == 2'd1 && !sh_q[0]) ? 9'd59 : 9'd5;
      rd_smp = state_q == SLOT_REL && tick_q && us_q == 9'd14 && op_q == 2'd2;
      slot_end = state_q == SLOT_REL && tick_q && us_q == 9'd69;
      cnt_d = (accept || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      tick_d = !accept && cnt_q == CNT_MAX;
      us_d = tick_q ? us_q + 1'b1 : us_q;
      state_d = state_q;
      bit_d = bit_q;
      op_d = op_q;
      sh_d = rd_smp ? {dq_s, sh_q[7:1]} : sh_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = cmd == 2'd0 ? RST_LOW : cmd == 2'd3 ? DONE : SLOT_LOW;
            op_d = cmd;
            sh_d = wr_data;
            us_d = '0;
            bit_d = '0;
         end
         RST_LOW: if (tick_q && us_q == 9'd479) begin
            state_d = RST_WAIT;
            us_d = '0;
         end
         RST_WAIT: begin
            if (tick_q && us_q == 9'd69) sh_d[0] = dq_s;
            if (tick_q && us_q == 9'd479) state_d = DONE;
         end
         SLOT_LOW: if (tick_q && us_q == low_end) state_d = SLOT_REL;
         SLOT_REL: if (slot_end) begin
            state_d = bit_q == 3'd7 ? DONE : SLOT_LOW;
            us_d = '0;
            bit_d = bit_q + 1'b1;
            sh_d = op_q == 2'd1 ? {1'b0, sh_q[7:1]} : sh_q;
         end
         default: state_d = IDLE;
      endcase
      // driving from the next state keeps dq_oe edges on the tick edges, one cycle after accept
      dq_oe_d = state_q != IDLE && (state_d == RST_LOW || state_d == SLOT_LOW);
      rsp_data_d = (state_q == DONE && op_q == 2'd2) ? sh_q : rsp_data_q;
      presence_d = (state_q == DONE && op_q == 2'd0) ? !sh_q[0] : presence_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         tick_q <= 1'b0;
         us_q <= '0;
         bit_q <= '0;
         sh_q <= '0;
         op_q <= '0;
         sync_q <= 2'b11;
         dq_oe_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q <= '0;
         presence_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         tick_q <= tick_d;
         us_q <= us_d;
         bit_q <= bit_d;
         sh_q <= sh_d;
         op_q <= op_d;
         sync_q <= {sync_q[0], dq_in};
         dq_oe_q <= dq_oe_d;
         rsp_valid_q <= state_q == DONE;
         rsp_data_q <= rsp_data_d;
         presence_q <= presence_d;
      end
   end
`ifdef ONEWIRE_CRC_EN
   logic [7:0] crc_q;
   always_ff @(posedge clk) begin
      if (rst || (accept && cmd == 2'd0)) crc_q <= '0;
      else if (rd_smp) crc_q <= {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ dq_s) ? 8'h8C : 8'h00);
   end
   assign crc = crc_q;
`endif
endmodule

// File: tb/tb_onewire_master.sv
// tb_onewire_master: scoreboard bench with a behavioural 1-Wire slave for onewire_master.
module tb_onewire_master;
   localparam int M = 4;
   typedef struct {int start; int len;} pulse_t;
   typedef struct {logic [1:0] op; logic [7:0] data; logic pres; logic [7:0] crc; int at;} exp_t;
   logic clk = 0, rst = 1, cmd_valid = 0, dev_low, dq_in;
   logic [1:0] cmd = 0;
   logic [7:0] wr_data = 0, rsp_data;
   logic cmd_ready, rsp_valid, presence, busy, dq_oe;
`ifdef ONEWIRE_CRC_EN
   logic [7:0] crc;
`endif
   int checks = 0, errors = 0, cyc = 0;
   pulse_t pul_q[$];
   exp_t exp_q[$];
   logic [7:0] m_data = 0, m_crc = 0;
   logic m_pres = 0;
   bit s_rd = 0, s_pres = 0, s_prev = 0, mon_prev = 0, chk_rdy = 0;
   logic [7:0] s_byte = 0;
   int s_idx = 0, s_fall = 0, pf = 0, pt = 0, hold = 0, mon_rise = 0;

   onewire_master #(.CLK_MHZ(M)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
      .wr_data(wr_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .presence(presence),
      .busy(busy),
`ifdef ONEWIRE_CRC_EN
      .crc(crc),
`endif
      .dq_oe(dq_oe), .dq_in(dq_in));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign dq_in = !(dq_oe || dev_low);

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 8'h8C : 8'h00);
      return r;
   endfunction

   task automatic issue(input logic [1:0] op, input logic [7:0] d, input bit pres, output int acc);
      int t;
      t = 0;
      while (!cmd_ready && t < 10000) begin @(posedge clk); #1; t++; end
      chk("ready", cmd_ready, 1);
      s_pres = pres; s_byte = d; s_idx = 0; s_rd = op == 2'd2;
      cmd = op; wr_data = d; cmd_valid = 1;
      @(posedge clk); #1;
      cmd_valid = 0;
      acc = cyc;
      if (op == 2'd0) begin
         pul_q.push_back('{acc + 1, 480 * M});
         m_pres = pres;
         m_crc = 0;
      end
      if (op == 2'd1 || op == 2'd2)
         for (int j = 0; j < 8; j++)
            pul_q.push_back('{acc + 1 + 70 * j * M, (op == 2'd2 || d[j]) ? 6 * M : 60 * M});
      if (op == 2'd2) begin
         m_data = d;
         m_crc = crc_byte(m_crc, d);
      end
      exp_q.push_back('{op, m_data, m_pres, m_crc, op == 2'd3 ? -1 : acc + (op == 2'd0 ? 960 : 560) * M + 2});
   endtask

   // behavioural slave: presence pulse after a long low, and holds the bus low in read slots for 0 bits
   initial begin
      dev_low = 0;
      forever begin
         @(posedge clk); #1;
         if (dq_oe && !s_prev) begin
            s_fall = cyc;
            if (s_rd && s_idx < 8) begin
               if (!s_byte[s_idx]) hold = cyc + 30 * M;
               s_idx++;
            end
         end
         if (!dq_oe && s_prev && cyc - s_fall >= 400 * M && s_pres) begin
            pf = cyc + 15 * M;
            pt = cyc + 255 * M;
         end
         s_prev = dq_oe;
         dev_low = (cyc >= pf && cyc < pt) || cyc < hold;
      end
   end

   initial begin
      pulse_t p;
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (chk_rdy) begin
            chk("ready_after_rsp", cmd_ready, 1);
            chk("busy_after_rsp", busy, 0);
            chk_rdy = 0;
         end
         if (dq_oe && !mon_prev) mon_rise = cyc;
         if (!dq_oe && mon_prev) begin
            chk("pulse_queued", int'(pul_q.size() > 0), 1);
            if (pul_q.size() > 0) begin
               p = pul_q.pop_front();
               chk("pulse_start", mon_rise, p.start);
               chk("pulse_len", cyc - mon_rise, p.len);
            end
         end
         mon_prev = dq_oe;
         if (rsp_valid) begin
            chk("rsp_queued", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("rsp_data", rsp_data, e.data);
               chk("presence", presence, e.pres);
               if (e.at >= 0) chk("rsp_cycle", cyc, e.at);
`ifdef ONEWIRE_CRC_EN
               chk("crc", crc, e.crc);
`endif
               chk_rdy = 1;
            end
         end
      end
   end

   initial begin
      int acc, t;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("reset_ready", cmd_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_dq_oe", dq_oe, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_presence", presence, 0);
`ifdef ONEWIRE_CRC_EN
      chk("reset_crc", crc, 0);
`endif
      issue(2'd0, 8'h00, 1, acc);
      issue(2'd0, 8'h00, 0, acc);
      issue(2'd1, 8'hCC, 0, acc);
      issue(2'd2, 8'hA5, 0, acc);
      issue(2'd3, 8'h5A, 0, acc);
      issue(2'd0, 8'h00, 1, acc);
      issue(2'd2, 8'h01, 0, acc);
      issue(2'd2, 8'h5E, 0, acc);
      for (int i = 0; i < 6; i++) issue(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), acc);
      issue(2'd0, 8'h00, 1, acc);
      issue(2'd2, 8'h3C, 0, acc);
      issue(2'd2, 8'h0F, 0, acc);
      cmd = 2'd1; wr_data = 8'hFF; cmd_valid = 1;
      while (cyc < acc + 200 * M) begin @(posedge clk); #1; end
      pul_q.delete(); exp_q.delete();
      s_rd = 0; hold = 0; cmd_valid = 0; rst = 1;
      @(posedge clk); #1;
      rst = 0; m_data = 0; m_pres = 0; m_crc = 0;
      chk("abort_dq_oe", dq_oe, 0);
      chk("abort_ready", cmd_ready, 1);
      chk("abort_rsp_data", rsp_data, 0);
      chk("abort_presence", presence, 0);
      repeat (50 * M) begin @(posedge clk); #1; end
      issue(2'd0, 8'h00, 1, acc);
      issue(2'd1, 8'h81, 0, acc);
      t = 0;
      while ((exp_q.size() > 0 || pul_q.size() > 0) && t < 6000 * M) begin @(posedge clk); #1; t++; end
      repeat (2) begin @(posedge clk); #1; end
      chk("drain", exp_q.size() + pul_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
